// File: rtl/map_ss_seq.sv
// Save-state sequencer: streams mapper state bytes out (dump) or back in (restore).
// Each restore write is held on ss_we until a synchronised falling edge of m2 has been seen.
`timescale 1ns/1ps

module map_ss_seq #(
  parameter int         SS_LEN   = 15,
  parameter logic [7:0] IDX_ADDR = 8'd127,
  parameter logic [7:0] MAP_IDX  = 8'd106,
  parameter int         RD_WAIT  = 2,
  parameter int         M2_TMO   = 1023
) (
  input  logic       clk,
  input  logic       map_rst,
  input  logic       m2,
  input  logic       cmd_dump,
  input  logic       cmd_load,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ss_act,
  output logic [7:0] ss_addr,
  output logic       ss_we,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat,
  output logic [7:0] out_dat,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [7:0] in_dat,
  input  logic       in_valid,
  output logic       in_ready
);

  localparam int TMO_W = $clog2(M2_TMO + 1);
  localparam int CNT_W = (TMO_W > 4) ? TMO_W : 4;

  localparam logic [7:0]       LAST_ADDR = 8'(SS_LEN - 1);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(M2_TMO - 1);
  localparam logic [CNT_W-1:0] FALL_MIN  = CNT_W'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_SET,
    S_RD_PUSH,
    S_LD_HDR,
    S_LD_WAIT,
    S_LD_HOLD,
    S_LD_REL,
    S_FIN
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_ss_addr;
  logic [7:0]       r_ss_wdat;
  logic [7:0]       r_out_dat;
  logic             r_ss_act;
  logic             r_ss_we;
  logic             r_done;
  logic             r_err;
  logic             r_out_valid;
  logic             r_in_ready;

  logic r_m2_s1;
  logic r_m2_s2;
  logic r_m2_prev;

  logic w_m2_fall;
  logic w_in_xfer;
  logic w_out_xfer;
  logic w_last;

  // NOTE: every clocked register uses non-blocking assignments so all flops
  // update together from the values present before the edge.
  always_ff @(posedge clk or posedge map_rst) begin
    if (map_rst) begin
      r_m2_s1   <= 1'b0;
      r_m2_s2   <= 1'b0;
      r_m2_prev <= 1'b0;
    end else begin
      r_m2_s1   <= m2;
      r_m2_s2   <= r_m2_s1;
      r_m2_prev <= r_m2_s2;
    end
  end

  assign w_m2_fall  = r_m2_prev & ~r_m2_s2;
  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;
  assign w_last     = (r_ss_addr == LAST_ADDR);

  always_ff @(posedge clk or posedge map_rst) begin
    if (map_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ss_addr   <= 8'd0;
      r_ss_wdat   <= 8'd0;
      r_out_dat   <= 8'd0;
      r_ss_act    <= 1'b0;
      r_ss_we     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_dump) begin
            r_state   <= S_RD_SET;
            r_ss_addr <= IDX_ADDR;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_ss_act  <= 1'b1;
          end else if (cmd_load) begin
            r_state    <= S_LD_HDR;
            r_in_ready <= 1'b1;
            r_err      <= 1'b0;
            r_ss_act   <= 1'b1;
          end
        end

        S_RD_SET: begin
          if (r_cnt == RD_LAST) begin
            r_out_dat   <= ss_rdat;
            r_out_valid <= 1'b1;
            r_state     <= S_RD_PUSH;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_RD_PUSH: begin
          if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            if (w_last) begin
              r_state  <= S_FIN;
              r_ss_act <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_ss_addr <= (r_ss_addr == IDX_ADDR) ? 8'd0 : r_ss_addr + 8'd1;
              r_cnt     <= '0;
              r_state   <= S_RD_SET;
            end
          end
        end

        S_LD_HDR: begin
          if (w_in_xfer) begin
            if (in_dat != MAP_IDX) begin
              r_in_ready <= 1'b0;
              r_err      <= 1'b1;
              r_ss_act   <= 1'b0;
              r_state    <= S_FIN;
            end else begin
              r_ss_addr <= 8'd0;
              r_state   <= S_LD_WAIT;
            end
          end
        end

        S_LD_WAIT: begin
          if (w_in_xfer) begin
            r_ss_wdat  <= in_dat;
            r_in_ready <= 1'b0;
            r_ss_we    <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_LD_HOLD;
          end
        end

        // A fall seen in the first two hold cycles happened before ss_we rose,
        // so the mapper did not latch it; wait for the next one instead.
        S_LD_HOLD: begin
          if (w_m2_fall && (r_cnt >= FALL_MIN)) begin
            r_ss_we <= 1'b0;
            r_state <= S_LD_REL;
          end else if (r_cnt == TMO_LAST) begin
            r_ss_we  <= 1'b0;
            r_err    <= 1'b1;
            r_ss_act <= 1'b0;
            r_state  <= S_FIN;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_LD_REL: begin
          if (w_last) begin
            r_state  <= S_FIN;
            r_ss_act <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_ss_addr  <= r_ss_addr + 8'd1;
            r_in_ready <= 1'b1;
            r_state    <= S_LD_WAIT;
          end
        end

        S_FIN: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_ss_act;
  assign ss_act    = r_ss_act;
  assign done      = r_done;
  assign err       = r_err;
  assign ss_addr   = r_ss_addr;
  assign ss_we     = r_ss_we;
  assign ss_wdat   = r_ss_wdat;
  assign out_dat   = r_out_dat;
  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;

endmodule

// File: tb/tb_map_ss_seq.sv
// Bench for map_ss_seq: mapper model on negedge m2, table of directed operations,
// hand-written latency/reset sequences, then randomised operations against a byte-level model.
`timescale 1ns/1ps

module tb_map_ss_seq;

  localparam int         SS_LEN   = 15;
  localparam logic [7:0] IDX_ADDR = 8'd127;
  localparam logic [7:0] MAP_IDX  = 8'd106;
  localparam int         RD_WAIT  = 2;
  localparam int         M2_TMO   = 1023;

  logic       clk = 1'b0;
  logic       map_rst;
  logic       m2;
  logic       cmd_dump, cmd_load;
  logic       busy, done, err, ss_act, ss_we;
  logic [7:0] ss_addr, ss_wdat, ss_rdat;
  logic [7:0] out_dat;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] in_dat;
  logic       in_valid, in_ready;

  map_ss_seq #(
    .SS_LEN(SS_LEN), .IDX_ADDR(IDX_ADDR), .MAP_IDX(MAP_IDX),
    .RD_WAIT(RD_WAIT), .M2_TMO(M2_TMO)
  ) dut (
    .clk(clk), .map_rst(map_rst), .m2(m2),
    .cmd_dump(cmd_dump), .cmd_load(cmd_load),
    .busy(busy), .done(done), .err(err), .ss_act(ss_act),
    .ss_addr(ss_addr), .ss_we(ss_we), .ss_wdat(ss_wdat), .ss_rdat(ss_rdat),
    .out_dat(out_dat), .out_valid(out_valid), .out_ready(out_ready),
    .in_dat(in_dat), .in_valid(in_valid), .in_ready(in_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // m2 edges always land at 3 ns mod 10, clear of both clk edges.
  bit m2_on   = 1'b1;
  int m2_half = 60;
  initial begin
    m2 = 1'b1;
    #3;
    forever begin
      if (m2_on) begin
        #(m2_half) m2 = ~m2;
      end else begin
        m2 = 1'b1;
        #10;
      end
    end
  end

  // Mapper: register file latched on negedge m2 while ss_we is high.
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  int fall_cnt = 0;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    forever begin
      @(negedge m2);
      if (ss_we) begin
        mem[ss_addr] = ss_wdat;
        fall_cnt++;
      end
    end
  end
  assign ss_rdat = mem[ss_addr];

  int rmode = 0;
  int rcnt  = 0;
  always @(posedge clk) begin
    #1;
    rcnt++;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       if (rcnt % 3 == 0) out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Stream/strobe monitor, sampled on the falling clk edge.
  logic [7:0] got_q [$];
  int   we_cnt   = 0;
  int   done_cnt = 0;
  int   fall_at_rise = 0;
  bit   we_prev  = 1'b0;
  bit   span_chk = 1'b0;
  bit   st_prev  = 1'b0;
  logic [7:0] st_dat = 8'd0;
  always @(negedge clk) begin
    if (ss_we && !we_prev) begin
      we_cnt++;
      fall_at_rise = fall_cnt;
    end
    if (!ss_we && we_prev && span_chk)
      check("we_span_fall", 32'(fall_cnt != fall_at_rise), 32'd1);
    we_prev = ss_we;
    if (done) done_cnt++;
    if (st_prev) check("stall_hold", {out_valid, out_dat}, {1'b1, st_dat});
    st_prev = out_valid && !out_ready;
    st_dat  = out_dat;
    if (out_valid && out_ready) got_q.push_back(out_dat);
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps, output bit ok);
    ok = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_dat   = b;
    in_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      if (!busy) break;
    end
    if (ok) begin @(posedge clk); #1; end
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input bit is_load, input bit both,
                        input logic [7:0] hdr, input int rm, input bit rand_data, input bit gaps,
                        input bit exp_err, input int exp_done, input int exp_we, input int exp_bytes);
    int we0, dn0, gb, c, bad;
    bit ok;
    logic [7:0] data [SS_LEN];
    logic [7:0] exp_q [$];
    we0 = we_cnt; dn0 = done_cnt; gb = got_q.size();
    rmode = rm;
    span_chk = m2_on;
    for (int i = 0; i < SS_LEN; i++) data[i] = rand_data ? 8'($urandom) : 8'h10 + 8'(i);
    if (!is_load) begin
      exp_q.push_back(ref_mem[IDX_ADDR]);
      for (int i = 0; i < SS_LEN; i++) exp_q.push_back(ref_mem[i]);
    end
    @(posedge clk); #1;
    cmd_dump = !is_load || both;
    cmd_load = is_load || both;
    @(posedge clk); #1;
    cmd_dump = 1'b0;
    cmd_load = 1'b0;
    check({name, "/busy_rise"}, busy, 1);
    if (is_load) begin
      send_byte(hdr, gaps, ok);
      if (hdr != MAP_IDX) begin
        c = 0;
        while (busy && c < 10) begin @(negedge clk); c++; end
        check({name, "/hdr_busy_fall"}, 32'(c <= 3), 1);
      end
      for (int i = 0; i < SS_LEN && ok; i++) send_byte(data[i], gaps, ok);
    end
    c = 0;
    while (busy && c < 3000) begin @(negedge clk); c++; end
    check({name, "/finished"}, busy, 0);
    repeat (2) @(negedge clk);
    if (is_load && !exp_err) for (int i = 0; i < SS_LEN; i++) ref_mem[i] = data[i];
    check({name, "/done_cnt"}, done_cnt - dn0, exp_done);
    check({name, "/err"}, err, exp_err);
    check({name, "/we_pulses"}, we_cnt - we0, exp_we);
    check({name, "/idle_outs"}, {ss_act, ss_we, in_ready, out_valid}, 0);
    check({name, "/n_bytes"}, got_q.size() - gb, exp_bytes);
    for (int i = 0; i < exp_q.size(); i++)
      if (gb + i < got_q.size()) check({name, "/byte"}, got_q[gb + i], exp_q[i]);
    bad = 0;
    for (int i = 0; i < SS_LEN; i++) if (mem[i] !== ref_mem[i]) bad++;
    check({name, "/mapper_mem"}, bad, 0);
  endtask

  typedef struct {
    string      name;
    bit         is_load;
    logic [7:0] hdr;
    bit         m2_on;
    int         rm;
    bit         exp_err;
    int         exp_done;
    int         exp_we;
    int         exp_bytes;
  } vec_t;

  initial begin
    vec_t tbl [6];
    int   n, we0, gb;
    bit   ok, is_load;
    logic [7:0] hdr;

    tbl[0] = '{"dump_rdy",      1'b0, 8'h00,   1'b1, 0, 1'b0, 1, 0,  16};
    tbl[1] = '{"dump_toggle",   1'b0, 8'h00,   1'b1, 1, 1'b0, 1, 0,  16};
    tbl[2] = '{"load_ok",       1'b1, MAP_IDX, 1'b1, 0, 1'b0, 1, 15, 0};
    tbl[3] = '{"load_bad_hdr",  1'b1, 8'h07,   1'b1, 0, 1'b1, 0, 0,  0};
    tbl[4] = '{"load_m2_stuck", 1'b1, MAP_IDX, 1'b0, 0, 1'b1, 0, 1,  0};
    tbl[5] = '{"dump_after",    1'b0, 8'h00,   1'b1, 0, 1'b0, 1, 0,  16};

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    map_rst = 1'b1; cmd_dump = 1'b0; cmd_load = 1'b0; in_valid = 1'b0; in_dat = 8'd0;

    repeat (3) @(posedge clk); #1;
    check("reset_outs", {busy, done, err, ss_act, ss_we, out_valid, in_ready, ss_addr, ss_wdat, out_dat}, 0);
    map_rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("idle_outs", {busy, done, err, ss_act, ss_we, out_valid, in_ready, ss_addr}, 0);

    for (int v = 0; v < 6; v++) begin
      if (m2_on != tbl[v].m2_on) begin
        m2_on = tbl[v].m2_on;
        repeat (20) @(posedge clk);
      end
      run_op(tbl[v].name, tbl[v].is_load, 1'b0, tbl[v].hdr, tbl[v].rm, 1'b0, 1'b0,
             tbl[v].exp_err, tbl[v].exp_done, tbl[v].exp_we, tbl[v].exp_bytes);
    end

    // Dump timing: busy one cycle after the command edge, first byte RD_WAIT+1 later.
    rmode = 0;
    gb = got_q.size();
    @(posedge clk); #1; cmd_dump = 1'b1;
    @(posedge clk); #1; cmd_dump = 1'b0;
    check("lat/busy", busy, 1);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("lat/first_valid", n, RD_WAIT + 1);
    @(posedge clk); #1; n = 1;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("lat/byte_period", n, RD_WAIT + 2);
    n = 0;
    while (busy && n < 200) begin @(posedge clk); #1; n++; end
    check("lat/done_at_busy_fall", {busy, done}, 2'b01);
    @(posedge clk); #1;
    check("lat/done_one_cycle", done, 0);
    check("lat/n_bytes", got_q.size() - gb, SS_LEN + 1);

    // Reset while the 5th restore byte is being written.
    span_chk = 1'b1;
    we0 = we_cnt;
    @(posedge clk); #1; cmd_load = 1'b1;
    @(posedge clk); #1; cmd_load = 1'b0;
    send_byte(MAP_IDX, 1'b0, ok);
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b0, ok);
    check("rst/we_high", ss_we, 1);
    span_chk = 1'b0;
    map_rst = 1'b1;
    #1;
    check("rst/outs_zero", {busy, done, err, ss_act, ss_we, out_valid, in_ready, ss_addr, ss_wdat, out_dat}, 0);
    for (int i = 0; i < 4; i++) ref_mem[i] = 8'hA0 + 8'(i);
    n = 0;
    for (int i = 0; i < SS_LEN; i++) if (mem[i] !== ref_mem[i]) n++;
    check("rst/mapper_keeps", n, 0);
    repeat (2) @(posedge clk); #1;
    map_rst = 1'b0;
    run_op("both_cmds", 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1, 0, SS_LEN + 1);

    for (int r = 0; r < 10; r++) begin
      m2_half = 10 * $urandom_range(4, 10);
      is_load = 1'($urandom_range(0, 1));
      hdr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : MAP_IDX;
      if (is_load)
        run_op("rnd_load", 1'b1, 1'b0, hdr, 2, 1'b1, 1'b1, hdr != MAP_IDX,
               (hdr != MAP_IDX) ? 0 : 1, (hdr != MAP_IDX) ? 0 : SS_LEN, 0);
      else
        run_op("rnd_dump", 1'b0, 1'b0, 8'h00, 2, 1'b1, 1'b1, 1'b0, 1, 0, SS_LEN + 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #800us;
    $display("FAIL watchdog: simulation did not finish, failed so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
